fetch_line_buffer: RTL and testbench
====================================

FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 22, sets the RAM instruction-port byte-address width.
REQ-002 Parameter DEPTH, default 2, sets the number of 128-bit line entries (power of two, >=2).
REQ-003 Parameter BOOT_ADDR, default 32'h0000_0080, sets the first fetch address after reset.
REQ-004 Port clk, input, 1: the single clock; all state on rising edge.
REQ-005 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 Port fetch_en_i, input, 1: enables RAM line requests.
REQ-007 Port branch_i, input, 1: single-cycle redirect strobe.
REQ-008 Port branch_addr_i, input, 32: redirect target byte address.
REQ-009 Port instr_req_o, input side of RAM; direction output, 1: line request.
REQ-010 Port instr_addr_o, output, ADDR_WIDTH: line byte address, bits [3:0] always 0.
REQ-011 Port instr_gnt_i, input, 1: RAM grant.
REQ-012 Port instr_rvalid_i, input, 1: RAM line-data valid.
REQ-013 Port instr_rdata_i, input, 128: RAM line data; word n at bits [32n+31:32n].
REQ-014 Port fetch_valid_o, output, 1: instruction word valid to core.
REQ-015 Port fetch_rdata_o, output, 32: instruction word.
REQ-016 Port fetch_addr_o, output, 32: byte address of fetch_rdata_o.
REQ-017 Port fetch_ready_i, input, 1: core accepts word when high with fetch_valid_o.
REQ-018 Port busy_o, output, 1: high while a request is outstanding or the buffer is non-empty.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, DROP; IDLE->REQ when fetch_en_i and a free entry exists counting the outstanding line.
REQ-020 REQ holds instr_req_o=1 with stable instr_addr_o until instr_gnt_i; on grant -> WAIT.
REQ-021 WAIT on instr_rvalid_i writes the line into the FIFO with its line address, advances request address by 16, -> REQ if space and fetch_en_i else IDLE.
REQ-022 At most one request outstanding; request address wraps modulo 2**ADDR_WIDTH to 0.
REQ-023 Word transfer occurs when fetch_valid_o and fetch_ready_i; word offset increments, line popped after word 3; fetch_addr_o = line address + 4*offset.
REQ-024 branch_i flushes FIFO, sets request address to branch_addr_i[ADDR_WIDTH-1:4]<<4, first-line offset to branch_addr_i[3:2]; bits [1:0] ignored.
REQ-025 branch_i in WAIT -> DROP; DROP discards the next instr_rvalid_i line then -> REQ; branch_i in REQ before grant retargets address that cycle (request not dropped).
REQ-026 branch_i wins over a same-cycle word pop and a same-cycle rvalid write; fetch_valid_o forced 0 in the branch cycle.
REQ-027 Full: no request issued; empty: fetch_valid_o=0; simultaneous pop of last word and write into full FIFO accepted.
REQ-028 Latency: branch at T -> instr_req_o at T+1, rvalid at T+2 (1-cycle RAM), fetch_valid_o at T+3.

Reset
REQ-029 During rst_i: instr_req_o=0, instr_addr_o=0, fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0, busy_o=0, FIFO empty, state IDLE, request address BOOT_ADDR line-aligned, offset BOOT_ADDR[3:2].
REQ-030 Reset asserted mid-transfer abandons the outstanding request; an instr_rvalid_i in the first cycle after release is ignored.

Configuration
REQ-031 Macro FETCH_BYPASS_EN defined: when FIFO empty, an accepted rvalid line drives fetch_valid_o/fetch_rdata_o combinationally the same cycle (REQ-028 becomes T+2); line stored only if not fully consumed.
REQ-032 Macro FETCH_BYPASS_EN undefined: fetch outputs come only from FIFO registers; no instr_rdata_i-to-output combinational path.

Structure
REQ-033 Package fetch_pkg holds the FSM state enum typedef, LINE_BYTES=16, WORDS_PER_LINE=4.
REQ-034 Sub-module fetch_line_fifo holds line storage, read/write pointers and full/empty flags.

Verification
REQ-035 Reset release, BOOT_ADDR=0x80, fetch_en_i=1, ready=1 -> instr_addr_o 0x80, 0x90; fetch_addr_o 0x80,0x84,0x88,0x8C,0x90 consecutive cycles.
REQ-036 fetch_ready_i=0 with DEPTH=2 -> exactly two lines fetched, instr_req_o stays 0, busy_o=1.
REQ-037 branch_i to 0x1008 during WAIT -> stale line discarded, first word out fetch_addr_o=0x1008 then 0x100C, 0x1010.
REQ-038 Request address 2**ADDR_WIDTH-16 -> next instr_addr_o=0.
REQ-039 rst_i asserted while WAIT, released -> outputs zero, refetch starts at BOOT_ADDR.
REQ-040 With and without FETCH_BYPASS_EN: branch at T -> first fetch_valid_o at T+2 and T+3 respectively.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch line buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;

  // Byte address of word 'off' inside the line whose index is 'line_idx'.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] line_idx,
                                                 input logic [1:0]  off);
    return (line_idx << $clog2(LINE_BYTES)) | {28'd0, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_line_fifo.sv
// Line storage for the fetch buffer: DEPTH entries of 128-bit data plus line index,
// wrap-bit pointers, flush, and push-while-full allowed when a pop happens the same cycle.
module fetch_line_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LW    = 18
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_flush,
  input  logic                              i_wr,
  input  logic [32*WORDS_PER_LINE-1:0]      i_wr_data,
  input  logic [LW-1:0]                     i_wr_line,
  input  logic                              i_rd,
  output logic [32*WORDS_PER_LINE-1:0]      o_rd_data,
  output logic [LW-1:0]                     o_rd_line,
  output logic                              o_empty,
  output logic                              o_full,
  output logic [$clog2(DEPTH):0]            o_count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [PW:0]                      r_wptr;
  logic [PW:0]                      r_rptr;
  logic [32*WORDS_PER_LINE-1:0]     r_data [DEPTH];
  logic [LW-1:0]                    r_line [DEPTH];
  logic                             w_do_rd;
  logic                             w_do_wr;

  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (o_count == FULL_CNT);
  assign w_do_rd   = i_rd && !o_empty;
  assign w_do_wr   = i_wr && (!o_full || w_do_rd);
  assign o_rd_data = r_data[r_rptr[PW-1:0]];
  assign o_rd_line = r_line[r_rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_do_rd) r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_do_wr && !i_flush) begin
      r_data[r_wptr[PW-1:0]] <= i_wr_data;
      r_line[r_wptr[PW-1:0]] <= i_wr_line;
    end
  end

endmodule

// File: rtl/fetch_line_buffer.sv
// Instruction fetch line buffer: requests 16-byte lines from RAM, one outstanding at a time,
// and hands out 32-bit words. Define FETCH_BYPASS_EN to forward a returning line straight to the core.
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 22,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [31:0]           branch_addr_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [127:0]          instr_rdata_i,
  output logic                  fetch_valid_o,
  output logic [31:0]           fetch_rdata_o,
  output logic [31:0]           fetch_addr_o,
  input  logic                  fetch_ready_i,
  output logic                  busy_o
);

  localparam int              LW        = ADDR_WIDTH - 4;
  localparam int              PW        = $clog2(DEPTH);
  localparam logic [PW+1:0]   DEPTH_W   = (PW+2)'(DEPTH);
  localparam logic [1:0]      LAST_OFF  = 2'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0]   BOOT_LINE = BOOT_ADDR[ADDR_WIDTH-1:4];

  fetch_state_t   r_state;
  logic           r_req;
  logic [LW-1:0]  r_req_line;
  logic [1:0]     r_offset;

  logic [127:0]   w_head_data;
  logic [LW-1:0]  w_head_line;
  logic           w_empty;
  logic           w_full;
  logic [PW:0]    w_count;
  logic [PW+1:0]  w_count_nxt;
  logic           w_space_idle;
  logic           w_space_nxt;
  logic           w_accept;
  logic           w_valid;
  logic           w_fire;
  logic           w_last;
  logic           w_fifo_wr;
  logic           w_fifo_rd;
  logic [127:0]   w_src_data;
  logic [LW-1:0]  w_src_line;
  logic [31:0]    w_word;
  logic [LW-1:0]  w_branch_line;
  logic           w_unused;

  assign w_unused      = ^{branch_addr_i, w_full};
  assign w_branch_line = branch_addr_i[ADDR_WIDTH-1:4];
  assign w_accept      = (r_state == S_WAIT) && instr_rvalid_i && !branch_i;
  assign w_last        = (r_offset == LAST_OFF);
  assign w_fire        = w_valid && fetch_ready_i;
  assign w_fifo_rd     = w_fire && w_last;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  // A line arriving into an empty buffer is presented to the core in the same cycle.
  assign w_bypass   = w_empty && w_accept;
  assign w_valid    = (!w_empty || w_accept) && !branch_i;
  assign w_src_data = w_bypass ? instr_rdata_i : w_head_data;
  assign w_src_line = w_bypass ? r_req_line : w_head_line;
  assign w_fifo_wr  = w_accept && !(w_bypass && w_fire && w_last);
`else
  assign w_valid    = !w_empty && !branch_i;
  assign w_src_data = w_head_data;
  assign w_src_line = w_head_line;
  assign w_fifo_wr  = w_accept;
`endif

  assign w_count_nxt  = {1'b0, w_count} + (PW+2)'(w_fifo_wr) - (PW+2)'(w_fifo_rd && !w_empty);
  assign w_space_nxt  = (w_count_nxt < DEPTH_W);
  assign w_space_idle = ({1'b0, w_count} < DEPTH_W);
  assign w_word       = w_src_data[{r_offset, 5'd0} +: 32];

  assign fetch_valid_o = w_valid;
  assign fetch_rdata_o = w_valid ? w_word : 32'd0;
  assign fetch_addr_o  = w_valid ? word_byte_addr(32'(w_src_line), r_offset) : 32'd0;
  assign instr_req_o   = r_req;
  assign instr_addr_o  = r_req ? {r_req_line, 4'd0} : {ADDR_WIDTH{1'b0}};
  assign busy_o        = (r_state != S_IDLE) || !w_empty;

  fetch_line_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_i),
    .i_flush   (branch_i),
    .i_wr      (w_fifo_wr),
    .i_wr_data (instr_rdata_i),
    .i_wr_line (r_req_line),
    .i_rd      (w_fifo_rd),
    .o_rd_data (w_head_data),
    .o_rd_line (w_head_line),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count)
  );

  // Word offset within the head line; a branch sets the entry offset of its first line.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_offset <= BOOT_ADDR[3:2];
    end else if (branch_i) begin
      r_offset <= branch_addr_i[3:2];
    end else if (w_fire) begin
      r_offset <= w_last ? 2'd0 : r_offset + 2'd1;
    end else begin
      r_offset <= r_offset;
    end
  end

  // Request FSM: one outstanding line; a granted request made stale by a branch is dropped.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_req_line <= BOOT_LINE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (branch_i) r_req_line <= w_branch_line;
          if (fetch_en_i && (branch_i || w_space_idle)) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_REQ: begin
          if (branch_i) r_req_line <= w_branch_line;
          if (instr_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= branch_i ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (branch_i) begin
            r_req_line <= w_branch_line;
            if (!instr_rvalid_i) begin
              r_state <= S_DROP;
            end else if (fetch_en_i) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (instr_rvalid_i) begin
            r_req_line <= r_req_line + LW'(1);
            if (fetch_en_i && w_space_nxt) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (branch_i) r_req_line <= w_branch_line;
          if (instr_rvalid_i) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer with a one-cycle-latency RAM model.
// Expectations adapt to FETCH_BYPASS_EN (first word one cycle earlier).
module tb_fetch_line_buffer;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         fetch_en_i = 1'b0;
  logic         branch_i = 1'b0;
  logic [31:0]  branch_addr_i = 32'd0;
  logic         instr_req_o;
  logic [21:0]  instr_addr_o;
  logic         instr_gnt_i;
  logic         instr_rvalid_i;
  logic [127:0] instr_rdata_i;
  logic         fetch_valid_o;
  logic [31:0]  fetch_rdata_o;
  logic [31:0]  fetch_addr_o;
  logic         fetch_ready_i = 1'b0;
  logic         busy_o;

  logic         hold = 1'b0;
  logic         force_rv = 1'b0;
  logic         r_pend;
  logic [21:0]  r_paddr;
  int           lines_cnt = 0;
  int           n_total = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  fetch_line_buffer dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .fetch_en_i     (fetch_en_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_ready_i  (fetch_ready_i),
    .busy_o         (busy_o)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd7);
  endfunction

  // RAM: immediate grant, data one cycle later unless held off.
  assign instr_gnt_i    = instr_req_o;
  assign instr_rvalid_i = (r_pend && !hold) || force_rv;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_pend  <= 1'b0;
      r_paddr <= 22'd0;
    end else if (instr_req_o && instr_gnt_i) begin
      r_pend  <= 1'b1;
      r_paddr <= instr_addr_o;
    end else if (instr_rvalid_i) begin
      r_pend  <= 1'b0;
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) instr_rdata_i[32*n +: 32] = pat({10'd0, r_paddr} + 32'(4*n));
  end

  always @(posedge clk) begin
    if (instr_rvalid_i && !rst_i) lines_cnt <= lines_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   32'(instr_req_o),   32'd0);
    chk({tag, "_iaddr"}, 32'(instr_addr_o),  32'd0);
    chk({tag, "_valid"}, 32'(fetch_valid_o), 32'd0);
    chk({tag, "_rdata"}, fetch_rdata_o,      32'd0);
    chk({tag, "_faddr"}, fetch_addr_o,       32'd0);
    chk({tag, "_busy"},  32'(busy_o),        32'd0);
  endtask

  // Assert reset, check idle outputs, release with a spurious rvalid; returns one cycle after release.
  task automatic rst_seq(input string tag);
    rst_i = 1'b1;
    #1;
    chk_zero({tag, "_a"});
    nxt();
    nxt();
    chk_zero({tag, "_b"});
    rst_i    = 1'b0;
    force_rv = 1'b1;
    nxt();
    force_rv = 1'b0;
    #1;
  endtask

  task automatic boot_stream(input string tag);
    logic [31:0] e;
    chk({tag, "_req1"},   32'(instr_req_o),  32'd1);
    chk({tag, "_iaddr1"}, 32'(instr_addr_o), 32'h80);
    chk({tag, "_busy1"},  32'(busy_o),       32'd1);
    nxt();
    chk({tag, "_req2"},   32'(instr_req_o),   32'd0);
    chk({tag, "_valid2"}, 32'(fetch_valid_o), 32'(BYP));
    chk({tag, "_faddr2"}, fetch_addr_o, (BYP == 1) ? 32'h80 : 32'h0);
    for (int j = 0; j < 5; j++) begin
      nxt();
      e = 32'h80 + 32'(4 * (j + BYP));
      chk({tag, "_faddr"}, fetch_addr_o,  e);
      chk({tag, "_rdata"}, fetch_rdata_o, pat(e));
      if (j == 0) begin
        chk({tag, "_req3"},   32'(instr_req_o),  32'd1);
        chk({tag, "_iaddr3"}, 32'(instr_addr_o), 32'h90);
      end
    end
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!instr_req_o && k < 20) begin
      nxt();
      k++;
    end
    chk(tag, 32'(instr_req_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] cexp [3];
    logic [31:0] dseq [6];
    int          snap;
    cexp = '{32'h1008, 32'h100C, 32'h1010};
    dseq = '{32'h3FFFF0, 32'h3FFFF4, 32'h3FFFF8, 32'h3FFFFC, 32'h0, 32'h4};

    // Boot streaming with a spurious rvalid right after reset release.
    fetch_en_i    = 1'b1;
    fetch_ready_i = 1'b1;
    rst_seq("rA");
    boot_stream("A");

    // Core stalled: buffer fills with exactly DEPTH lines, then requests stop.
    fetch_ready_i = 1'b0;
    rst_seq("rB");
    snap = lines_cnt;
    for (int i = 0; i < 12; i++) nxt();
    chk("B_lines", 32'(lines_cnt - snap), 32'd2);
    chk("B_req",   32'(instr_req_o),      32'd0);
    chk("B_busy",  32'(busy_o),           32'd1);
    chk("B_faddr", fetch_addr_o,          32'h80);

    // Branch while a line is outstanding: stale line dropped, entry offset honoured.
    fetch_ready_i = 1'b1;
    hold          = 1'b1;
    wait_req("C_req_seen");
    nxt();
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_100B;
    #1;
    chk("C_valid_br", 32'(fetch_valid_o), 32'd0);
    chk("C_rdata_br", fetch_rdata_o,      32'd0);
    nxt();
    branch_i = 1'b0;
    hold     = 1'b0;
    #1;
    chk("C_valid_drop", 32'(fetch_valid_o), 32'd0);
    chk("C_req_drop",   32'(instr_req_o),   32'd0);
    chk("C_busy_drop",  32'(busy_o),        32'd1);
    nxt();
    chk("C_req_new",   32'(instr_req_o),  32'd1);
    chk("C_iaddr_new", 32'(instr_addr_o), 32'h1000);
    nxt();
    chk("C_faddr_rv", fetch_addr_o, (BYP == 1) ? 32'h1008 : 32'h0);
    for (int j = BYP; j < 3; j++) begin
      if (j != BYP) nxt();
      else if (BYP == 0) nxt();
      chk("C_faddr", fetch_addr_o,  cexp[j]);
      chk("C_rdata", fetch_rdata_o, pat(cexp[j]));
    end

    // Branch from idle to the top line of the RAM window: latency and address wrap.
    fetch_en_i = 1'b0;
    rst_seq("rD");
    chk("D_req_idle", 32'(instr_req_o), 32'd0);
    branch_i      = 1'b1;
    branch_addr_i = 32'h003F_FFF0;
    fetch_en_i    = 1'b1;
    #1;
    chk("D_valid_br", 32'(fetch_valid_o), 32'd0);
    nxt();
    branch_i = 1'b0;
    #1;
    chk("D_req_t1",   32'(instr_req_o),  32'd1);
    chk("D_iaddr_t1", 32'(instr_addr_o), 32'h3FFFF0);
    nxt();
    chk("D_valid_t2", 32'(fetch_valid_o), 32'(BYP));
    chk("D_faddr_t2", fetch_addr_o, (BYP == 1) ? 32'h3FFFF0 : 32'h0);
    for (int k = 0; k < 5; k++) begin
      nxt();
      if (k == 0) begin
        chk("D_req_wrap",   32'(instr_req_o),  32'd1);
        chk("D_iaddr_wrap", 32'(instr_addr_o), 32'h0);
      end
      chk("D_faddr", fetch_addr_o,  dseq[k + BYP]);
      chk("D_rdata", fetch_rdata_o, pat(dseq[k + BYP]));
    end

    // Reset while waiting for line data, then a clean refetch from the boot address.
    wait_req("E_req_seen");
    nxt();
    rst_seq("rE");
    boot_stream("E");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
